// File: rtl/param_light_control.sv
// rtl/param_light_control.sv - parametrised highway/country traffic-light controller
module param_light_control #(
    parameter int CNT_W       = 5,
    parameter int H_GREEN_MIN = 8,
    parameter int C_GREEN_MIN = 4,
    parameter int C_GREEN_MAX = 16,
    parameter int YELLOW_T    = 3,
    parameter int ALLRED_T    = 2
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       car_h,
    input  logic       car_c,
    input  logic       emerg,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        H_GREEN   = 3'd0,
        H_YELLOW  = 3'd1,
        ALLRED_HC = 3'd2,
        C_GREEN   = 3'd3,
        C_YELLOW  = 3'd4,
        ALLRED_CH = 3'd5
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    // Timer thresholds expressed as the timer value seen on the exit edge
    localparam logic [CNT_W-1:0] TIMER_SAT = '1;
    localparam logic [CNT_W-1:0] H_MIN_T   = CNT_W'(H_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] C_MIN_T   = CNT_W'(C_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] C_MAX_T   = CNT_W'(C_GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_T     = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ARED_T    = CNT_W'(ALLRED_T - 1);

    logic [1:0]       car_h_sync;
    logic [1:0]       car_c_sync;
    logic [1:0]       emerg_sync;
    logic             car_h_s;
    logic             car_c_s;
    logic             emerg_s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            car_h_sync <= 2'b00;
            car_c_sync <= 2'b00;
            emerg_sync <= 2'b00;
        end else begin
            car_h_sync <= {car_h_sync[0], car_h};
            car_c_sync <= {car_c_sync[0], car_c};
            emerg_sync <= {emerg_sync[0], emerg};
        end
    end

    assign car_h_s = car_h_sync[1];
    assign car_c_s = car_c_sync[1];
    assign emerg_s = emerg_sync[1];

    always_comb begin
        state_nxt = state;
        case (state)
            H_GREEN: begin
                if (timer >= H_MIN_T && car_c_s && !emerg_s)
                    state_nxt = H_YELLOW;
            end
            H_YELLOW: begin
                if (timer == YEL_T)
                    state_nxt = ALLRED_HC;
            end
            ALLRED_HC: begin
                if (timer == ARED_T)
                    state_nxt = C_GREEN;
            end
            C_GREEN: begin
                // Emergency preempts the minimum; the max limit only bites with highway demand
                if (emerg_s || (timer >= C_MIN_T && !car_c_s) ||
                    (timer >= C_MAX_T && car_h_s))
                    state_nxt = C_YELLOW;
            end
            C_YELLOW: begin
                if (timer == YEL_T)
                    state_nxt = ALLRED_CH;
            end
            ALLRED_CH: begin
                if (timer == ARED_T)
                    state_nxt = H_GREEN;
            end
            default: state_nxt = H_GREEN;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= H_GREEN;
            timer <= '0;
            hwy   <= LAMP_GREEN;
            cntry <= LAMP_RED;
            phase <= 3'd0;
        end else begin
            state <= state_nxt;
            phase <= state_nxt;
            if (state_nxt != state)
                timer <= '0;
            else if (timer != TIMER_SAT)
                timer <= timer + 1'b1;
            case (state_nxt)
                H_GREEN:   begin hwy <= LAMP_GREEN;  cntry <= LAMP_RED;    end
                H_YELLOW:  begin hwy <= LAMP_YELLOW; cntry <= LAMP_RED;    end
                C_GREEN:   begin hwy <= LAMP_RED;    cntry <= LAMP_GREEN;  end
                C_YELLOW:  begin hwy <= LAMP_RED;    cntry <= LAMP_YELLOW; end
                default:   begin hwy <= LAMP_RED;    cntry <= LAMP_RED;    end
            endcase
        end
    end

endmodule

// File: tb/tb_param_light_control.sv
// tb/tb_param_light_control.sv - self-checking bench for param_light_control
module tb_param_light_control;

    localparam int H_MIN = 8, C_MIN = 4, C_MAX = 16, YEL = 3, ARED = 2;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       car_h = 1'b0;
    logic       car_c = 1'b0;
    logic       emerg = 1'b0;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] phase;

    int vectors = 0;
    int miscompares = 0;

    // Model: phase index, cycles spent in it, and the last two applied inputs
    int m_p = 0;
    int m_n = 0;
    bit d1_c = 0, d1_h = 0, d1_e = 0;
    bit d2_c = 0, d2_h = 0, d2_e = 0;

    param_light_control dut (
        .clk   (clk),
        .clear (clear),
        .car_h (car_h),
        .car_c (car_c),
        .emerg (emerg),
        .hwy   (hwy),
        .cntry (cntry),
        .phase (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int lamp_h(input int p);
        return (p == 0) ? 2 : (p == 1) ? 1 : 0;
    endfunction

    function automatic int lamp_c(input int p);
        return (p == 3) ? 2 : (p == 4) ? 1 : 0;
    endfunction

    function automatic void model_advance(input bit c, input bit h, input bit e);
        bit go;
        go = 0;
        case (m_p)
            0:    go = (m_n >= H_MIN - 1) && d2_c && !d2_e;
            1, 4: go = (m_n == YEL - 1);
            2, 5: go = (m_n == ARED - 1);
            3:    go = d2_e || (m_n >= C_MIN - 1 && !d2_c) || (m_n >= C_MAX - 1 && d2_h);
            default: go = 1;
        endcase
        if (go) begin
            m_p = (m_p + 1) % 6;
            m_n = 0;
        end else begin
            m_n++;
        end
        d2_c = d1_c; d2_h = d1_h; d2_e = d1_e;
        d1_c = c;    d1_h = h;    d1_e = e;
    endfunction

    task automatic compare();
        chk("hwy", int'(hwy), lamp_h(m_p));
        chk("cntry", int'(cntry), lamp_c(m_p));
        chk("phase", int'(phase), m_p);
        chk("no_conflict", int'(hwy != 2'b00 && cntry != 2'b00), 0);
    endtask

    // One clock cycle: check outputs, apply inputs, optionally pulse clear between edges
    task automatic step(input bit c, input bit h, input bit e, input bit rst);
        @(negedge clk);
        compare();
        car_c = c;
        car_h = h;
        emerg = e;
        if (rst) begin
            #2 clear = 1'b1;
            #1;
            chk("reset_hwy", int'(hwy), 2);
            chk("reset_cntry", int'(cntry), 0);
            chk("reset_phase", int'(phase), 0);
            #1 clear = 1'b0;
            m_p = 0; m_n = 0;
            d1_c = 0; d1_h = 0; d1_e = 0;
            d2_c = 0; d2_h = 0; d2_e = 0;
        end
        model_advance(c, h, e);
    endtask

    // Literal pin on the phase just after the next rising edge
    task automatic lit(input string name, input int exp);
        @(posedge clk);
        #1;
        chk({name, "_dut"}, int'(phase), exp);
        chk({name, "_model"}, m_p, exp);
    endtask

    initial begin
        bit rc, rh, re, rr;

        // Idle: no demand keeps highway green
        step(0, 0, 0, 1);
        for (int k = 2; k <= 60; k++) step(0, 0, 0, 0);
        lit("idle", 0);

        // Full cycle with demand on both roads
        step(1, 1, 0, 1);
        for (int k = 2; k <= 34; k++) begin
            step(1, 1, 0, 0);
            case (k)
                7:  lit("full_k7", 0);
                8:  lit("full_k8", 1);
                11: lit("full_k11", 2);
                13: lit("full_k13", 3);
                28: lit("full_k28", 3);
                29: lit("full_k29", 4);
                32: lit("full_k32", 5);
                34: lit("full_k34", 0);
                default: ;
            endcase
        end

        // Country demand drops on green entry: minimum green only
        step(1, 1, 0, 1);
        for (int k = 2; k <= 22; k++) begin
            step(k < 13, 1, 0, 0);
            case (k)
                16: lit("min_k16", 3);
                17: lit("min_k17", 4);
                19: lit("min_k19", 4);
                20: lit("min_k20", 5);
                default: ;
            endcase
        end

        // No highway demand: country green outlasts the max limit
        step(1, 0, 0, 1);
        for (int k = 2; k <= 48; k++) begin
            step(1, k >= 43, 0, 0);
            case (k)
                30: lit("max_k30", 3);
                44: lit("max_k44", 3);
                45: lit("max_k45", 4);
                default: ;
            endcase
        end

        // Emergency during country green
        step(1, 1, 0, 1);
        for (int k = 2; k <= 45; k++) begin
            step(1, 1, k >= 14, 0);
            case (k)
                15: lit("emg_k15", 3);
                16: lit("emg_k16", 4);
                19: lit("emg_k19", 5);
                21: lit("emg_k21", 0);
                45: lit("emg_k45", 0);
                default: ;
            endcase
        end

        // Clear mid country yellow, then a fresh highway green
        step(1, 1, 0, 1);
        for (int k = 2; k <= 30; k++) step(1, 1, 0, 0);
        lit("pre_clr", 4);
        step(1, 1, 0, 1);
        for (int k = 2; k <= 8; k++) begin
            step(1, 1, 0, 0);
            if (k == 7) lit("clr_k7", 0);
            if (k == 8) lit("clr_k8", 1);
        end

        // Randomised traffic with occasional emergencies and clears
        rc = 0; rh = 0; re = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(11) == 0) rc = ~rc;
            if ($urandom_range(11) == 0) rh = ~rh;
            if (re) begin
                if ($urandom_range(29) == 0) re = 0;
            end else if ($urandom_range(79) == 0) begin
                re = 1;
            end
            rr = ($urandom_range(399) == 0);
            step(rc, rh, re, rr);
        end
        step(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
